mult_seq_ctrl: RTL

MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

---
 rtl/mult_seq_ctrl_if.sv | 24 ++
 rtl/mult_seq_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// EX-stage multiplier handshake: issue/flush and operands in, stall/busy/done and product out.
// The master modport is the pipeline side and the slave modport is the sequencer.
interface mult_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             flush_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, flush_i, src1_i, src2_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, flush_i, src1_i, src2_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add multiplier that stalls the pipeline for WIDTH+1 cycles per mult.
// It produces the low WIDTH bits of the product, and flush aborts any multiply that is in flight.
module mult_seq_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk_i,
    input  logic           rst_i,
    mult_seq_ctrl_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;

    always_comb begin
        acc_d = acc_q;
        if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        mcand_q  <= bus.src1_i;
                        mplier_q <= bus.src2_i;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    // Fixed latency: always run WIDTH iterations, even if the multiplier empties early.
                    if (cnt_q == LAST) begin
                        result_q <= acc_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The issue cycle must stall before the FSM leaves IDLE, so stall is decoded from live inputs.
    assign bus.stall_o  = rst_i && !bus.flush_i &&
                          ((state_q == IDLE && bus.start_i) || state_q == RUN);
    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q && !bus.flush_i;
    assign bus.result_o = result_q;
endmodule
